// File: rtl/clk_gate_hyst_ctrl_if.sv
// Request/config/status bundle for the hysteretic clock-gate controller.
// The controller drives the slave side; the requester drives the master side.
interface clk_gate_hyst_ctrl_if #(
   parameter int NCH    = 4,
   parameter int HYST_W = 4
);
   logic [NCH-1:0]    ch_busy;
   logic [HYST_W-1:0] hyst_cfg;
   logic              pad_yy_test_en;
   logic [NCH-1:0]    gclk;
   logic [NCH-1:0]    ch_gated;

   modport master (
      output ch_busy,
      output hyst_cfg,
      output pad_yy_test_en,
      input  gclk,
      input  ch_gated
   );

   modport slave (
      input  ch_busy,
      input  hyst_cfg,
      input  pad_yy_test_en,
      output gclk,
      output ch_gated
   );
endinterface

// File: rtl/clk_gate_hyst_ctrl.sv
// Per-channel clock gating with idle hysteresis; wake latency one cycle, gate after hyst_cfg idle cycles.
// No backpressure: ch_busy is a level request. Macro CLK_GATE_HYST_EN compiles in the COUNT state and counters.
module clk_gate_hyst_ctrl #(
   parameter int NCH    = 4,
   parameter int HYST_W = 4
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst_b,
   clk_gate_hyst_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      COUNT = 2'd1,
      GATED = 2'd2
   } state_t;

   state_t         state_q [NCH];
   state_t         state_d [NCH];
   logic [NCH-1:0] en_q;
   logic [NCH-1:0] en_d;
   logic [NCH-1:0] latch_en;
   logic [NCH-1:0] gated;

`ifdef CLK_GATE_HYST_EN
   logic [HYST_W-1:0] cnt_q [NCH];
   logic [HYST_W-1:0] cnt_d [NCH];
`else
   logic hyst_cfg_unused;
   assign hyst_cfg_unused = ^bus.hyst_cfg;
`endif

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= RUN;
`ifdef CLK_GATE_HYST_EN
            cnt_q[i]   <= '0;
`endif
         end
         en_q <= '1;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
`ifdef CLK_GATE_HYST_EN
            cnt_q[i]   <= cnt_d[i];
`endif
         end
         en_q <= en_d;
      end
   end

   always_comb begin
      en_d  = '1;
      gated = '0;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
`ifdef CLK_GATE_HYST_EN
         cnt_d[i]   = cnt_q[i];
`endif
         case (state_q[i])
            RUN: begin
               if (!bus.ch_busy[i]) begin
`ifdef CLK_GATE_HYST_EN
                  // hyst_cfg is captured only here, so later config writes cannot stretch a running count
                  if (bus.hyst_cfg != '0) begin
                     state_d[i] = COUNT;
                     cnt_d[i]   = bus.hyst_cfg;
                  end else begin
                     state_d[i] = GATED;
                  end
`else
                  state_d[i] = GATED;
`endif
               end
            end
            COUNT: begin
`ifdef CLK_GATE_HYST_EN
               if (bus.ch_busy[i]) begin
                  state_d[i] = RUN;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] - HYST_W'(1);
                  if (cnt_q[i] == HYST_W'(1)) begin
                     state_d[i] = GATED;
                  end
               end
`else
               state_d[i] = RUN;
`endif
            end
            GATED: begin
               if (bus.ch_busy[i]) begin
                  state_d[i] = RUN;
               end
            end
            default: begin
               state_d[i] = RUN;
            end
         endcase
         en_d[i]  = (state_d[i] != GATED);
         gated[i] = (state_q[i] == GATED);
      end
   end

   // Enable only changes while the clock is low, so the AND below never chops a high phase.
   always_latch begin
      if (!forever_cpuclk) begin
         latch_en <= en_q;
      end
   end

   assign bus.gclk     = {NCH{forever_cpuclk}} & (latch_en | {NCH{bus.pad_yy_test_en}});
   assign bus.ch_gated = gated;

endmodule

// File: tb/tb_clk_gate_hyst_ctrl.sv
// Directed bench for clk_gate_hyst_ctrl: gating interval, wake, abort, test enable, reset.
// Works in both builds; hysteresis-only scenarios are compiled in with CLK_GATE_HYST_EN.
module tb_clk_gate_hyst_ctrl;
   localparam int NCH = 4;
   localparam int HW  = 4;

`ifdef CLK_GATE_HYST_EN
   localparam bit HYST_ON = 1'b1;
`else
   localparam bit HYST_ON = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   clk_gate_hyst_ctrl_if #(.NCH(NCH), .HYST_W(HW)) bus ();

   clk_gate_hyst_ctrl #(.NCH(NCH), .HYST_W(HW)) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   function automatic int eff(input int h);
      return HYST_ON ? h : 0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_low();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.ch_busy        = '0;
      bus.hyst_cfg       = 4'd3;
      bus.pad_yy_test_en = 1'b0;
      rst_n              = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (bus.ch_gated !== 4'h0) begin n_fail++; $display("FAIL reset_gated: got %h want 0", bus.ch_gated); end
      n_checks++;
      if (bus.gclk !== 4'hF) begin n_fail++; $display("FAIL reset_gclk_high: got %h want f", bus.gclk); end
      tick_low();
      n_checks++;
      if (bus.gclk !== 4'h0) begin n_fail++; $display("FAIL reset_gclk_low: got %h want 0", bus.gclk); end
      bus.ch_busy = '1;
      rst_n       = 1'b1;
      tick();
      n_checks++;
      if (bus.gclk !== 4'hF || bus.ch_gated !== 4'h0) begin
         n_fail++; $display("FAIL post_reset: gclk %h gated %h want f/0", bus.gclk, bus.ch_gated);
      end
   endtask

   // Drop ch_busy[ch]; the first tick is edge k. gclk pulses through k+e, ch_gated from k+e.
   task automatic test_idle(input int ch, input int h, input int h_late);
      int e;
      logic [NCH-1:0] m;
      e = eff(h);
      m = NCH'(1) << ch;
      bus.hyst_cfg    = HW'(h);
      bus.ch_busy[ch] = 1'b0;
      for (int n = 0; n <= e + 1; n++) begin
         tick();
         if (n == 0) bus.hyst_cfg = HW'(h_late);
         n_checks++;
         if (bus.gclk[ch] !== (n <= e)) begin
            n_fail++; $display("FAIL idle_gclk ch%0d h%0d edge+%0d: got %b want %b", ch, h, n, bus.gclk[ch], (n <= e));
         end
         n_checks++;
         if (bus.ch_gated[ch] !== (n >= e)) begin
            n_fail++; $display("FAIL idle_gated ch%0d h%0d edge+%0d: got %b want %b", ch, h, n, bus.ch_gated[ch], (n >= e));
         end
         n_checks++;
         if ((bus.gclk | m) !== 4'hF) begin
            n_fail++; $display("FAIL idle_others ch%0d edge+%0d: gclk %h want others high", ch, n, bus.gclk);
         end
      end
   endtask

   task automatic restore();
      bus.ch_busy = '1;
      repeat (2) tick();
   endtask

   task automatic test_wake();
      test_idle(1, 0, 0);
      bus.ch_busy[1] = 1'b1;
      tick();
      n_checks++;
      if (bus.ch_gated[1] !== 1'b0) begin n_fail++; $display("FAIL wake_gated: got %b want 0", bus.ch_gated[1]); end
      n_checks++;
      if (bus.gclk[1] !== 1'b0) begin n_fail++; $display("FAIL wake_no_early_pulse: got %b want 0", bus.gclk[1]); end
      tick_low();
      n_checks++;
      if (bus.gclk[1] !== 1'b0) begin n_fail++; $display("FAIL wake_low_phase: got %b want 0", bus.gclk[1]); end
      tick();
      n_checks++;
      if (bus.gclk[1] !== 1'b1) begin n_fail++; $display("FAIL wake_first_pulse: got %b want 1", bus.gclk[1]); end
   endtask

`ifdef CLK_GATE_HYST_EN
   task automatic test_abort();
      bus.hyst_cfg   = 4'd2;
      bus.ch_busy[2] = 1'b0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (n == 1) bus.ch_busy[2] = 1'b1;
         n_checks++;
         if (bus.gclk[2] !== 1'b1 || bus.ch_gated[2] !== 1'b0) begin
            n_fail++; $display("FAIL abort_terminal edge+%0d: gclk %b gated %b want 1/0", n, bus.gclk[2], bus.ch_gated[2]);
         end
      end
   endtask
`endif

   task automatic test_test_en();
      bus.hyst_cfg = 4'd1;
      bus.ch_busy  = '0;
      repeat (4) tick();
      n_checks++;
      if (bus.ch_gated !== 4'hF || bus.gclk !== 4'h0) begin
         n_fail++; $display("FAIL all_gated: gated %h gclk %h want f/0", bus.ch_gated, bus.gclk);
      end
      bus.pad_yy_test_en = 1'b1;
      tick();
      n_checks++;
      if (bus.gclk !== 4'hF || bus.ch_gated !== 4'hF) begin
         n_fail++; $display("FAIL test_en_high: gclk %h gated %h want f/f", bus.gclk, bus.ch_gated);
      end
      tick_low();
      n_checks++;
      if (bus.gclk !== 4'h0) begin n_fail++; $display("FAIL test_en_low_phase: got %h want 0", bus.gclk); end
      bus.pad_yy_test_en = 1'b0;
      tick();
      n_checks++;
      if (bus.gclk !== 4'h0 || bus.ch_gated !== 4'hF) begin
         n_fail++; $display("FAIL test_en_release: gclk %h gated %h want 0/f", bus.gclk, bus.ch_gated);
      end
      restore();
   endtask

   task automatic test_reset_mid();
      int e;
      e = eff(5);
      bus.hyst_cfg   = 4'd5;
      bus.ch_busy[3] = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (bus.ch_gated[3] !== (e < 2)) begin
         n_fail++; $display("FAIL pre_reset_state: got %b want %b", bus.ch_gated[3], (e < 2));
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.ch_gated !== 4'h0) begin n_fail++; $display("FAIL async_reset_gated: got %h want 0", bus.ch_gated); end
      tick();
      n_checks++;
      if (bus.gclk[3] !== 1'b1) begin n_fail++; $display("FAIL reset_gclk3: got %b want 1", bus.gclk[3]); end
      tick_low();
      rst_n = 1'b1;
      for (int n = 0; n <= e + 1; n++) begin
         tick();
         n_checks++;
         if (bus.gclk[3] !== (n <= e) || bus.ch_gated[3] !== (n >= e)) begin
            n_fail++; $display("FAIL post_reset_idle edge+%0d: gclk %b gated %b want %b/%b",
                               n, bus.gclk[3], bus.ch_gated[3], (n <= e), (n >= e));
         end
      end
      restore();
   endtask

   initial begin
      test_reset();
      test_idle(0, 3, 3);
      restore();
      test_wake();
      restore();
`ifdef CLK_GATE_HYST_EN
      test_abort();
      restore();
`endif
      test_idle(2, 0, 0);
      restore();
      test_idle(0, 5, 1);
      restore();
      test_test_en();
      test_reset_mid();
      test_idle(0, 7, 7);
      restore();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
